uart_frame_tx: RTL and testbench
================================

# uart_frame_tx

Framing stage directly upstream of the UART transmitter. It accepts one fixed-size message word on a valid/ready handshake and wraps it in a frame: sync byte, length byte, payload bytes, XOR checksum. It then feeds the frame byte-by-byte into the transmitter's `uart_tx_en` / `uart_tx_data` / `uart_tx_busy` interface. Trade/opportunity reports from the arbitrage core reach the host PC through this block.

## Interface
Parameters:
- `PAYLOAD_BYTES`, default 8: payload bytes per frame, range 1..255.
- `SYNC_BYTE`, default 8'hA5: first byte of every frame.

Ports:
- `clk`, in, 1: system clock. One clock domain.
- `reset`, in, 1: synchronous, active-high reset.
- `msg_valid`, in, 1: a message is offered.
- `msg_ready`, out, 1: the block can accept a message.
- `msg_data`, in, PAYLOAD_BYTES*8: message; byte 0 is `[7:0]` and is sent first.
- `uart_tx_en`, out, 1: one-cycle send strobe to the transmitter.
- `uart_tx_data`, out, 8: byte to send; valid while `uart_tx_en` is high.
- `uart_tx_busy`, in, 1: the transmitter is sending a byte.
- `frame_active`, out, 1: a frame is in progress.
- `frames_sent`, out, 16: count of completed frames; wraps.

## Operation
- Frame order: `SYNC_BYTE`, LEN (= `PAYLOAD_BYTES`, 8-bit), payload byte 0..N-1, CHK.
- CHK = XOR of LEN and all payload bytes. `SYNC_BYTE` is excluded.
- Total length is `PAYLOAD_BYTES`+3 bytes.
- Message latch: on `msg_valid && msg_ready`, `msg_data` is captured into an internal register. `msg_data` may change afterwards.
- `msg_ready` is high only in IDLE. There is no queuing; the next message waits until the frame completes.
- State machine:
  - IDLE: accept a message → ISSUE. Byte index = 0, checksum = LEN.
  - ISSUE: if `!uart_tx_busy`, drive `uart_tx_en`=1 with the current byte → GAP. Otherwise stay in ISSUE.
  - GAP: exactly one cycle, covering the transmitter's one-cycle delay before `busy` rises. `busy` is ignored here → DRAIN.
  - DRAIN: wait for `!uart_tx_busy`. Then either advance the byte index → ISSUE, or, if CHK was just sent, increment `frames_sent` → IDLE.
- Byte selection by index:
  - 0 → SYNC
  - 1 → LEN
  - 2..N+1 → payload[index-2]
  - N+2 → CHK
- The checksum accumulates payload bytes as they are issued.
- `frame_active` = (state != IDLE).
- `uart_tx_en` is never high in two consecutive cycles. It is never high while `uart_tx_busy` is high.
- Reset mid-frame: the frame is abandoned and all state returns to reset values. No partial-frame recovery; the host resyncs on `SYNC_BYTE`. The transmitter is reset by the same `reset`.
- `frames_sent` wraps from 16'hFFFF to 0.

## Timing
- Reset values:
  - `msg_ready`=1 (IDLE)
  - `uart_tx_en`=0
  - `uart_tx_data`=8'h00
  - `frame_active`=0
  - `frames_sent`=0
  - state IDLE
- `uart_tx_en` and `uart_tx_data` are registered outputs.
- Accept at cycle 0: the SYNC strobe appears at cycle 1 if `uart_tx_busy` was low at cycle 0 (ISSUE evaluated from registered state).
- After an `en` cycle, the next `en` comes no earlier than 2 cycles after `busy` falls.
- `frames_sent` increments in the cycle DRAIN sees `busy` low after CHK. `msg_ready` rises in the same cycle.
- Throughput per frame ≈ (N+3) × (UART byte time + 3 cycles).

## Structure
- Shared package `uart_frame_pkg` holds:
  - the state enum/localparams (IDLE, ISSUE, GAP, DRAIN)
  - the default `SYNC_BYTE`
  - the frame-overhead constant (3)
- Byte index width is `$clog2(PAYLOAD_BYTES+3)`.
- No sub-module: byte mux and checksum are inline.
- The bench instantiates the existing transmitter downstream, plus a UART receiver model.

## Test plan
- `PAYLOAD_BYTES`=4, `msg_data`=32'h44332211 → bytes A5 04 11 22 33 44 40 on `uart_tx_data`; `frames_sent`=1.
- Hold `uart_tx_busy` high externally for 20 cycles after accept → no `uart_tx_en` until `busy` falls; then SYNC is issued.
- Two back-to-back `msg_valid` pulses → second is held off by `msg_ready`=0 until the first frame's CHK drains; second frame is intact.
- Assert `reset` after the third byte's strobe → outputs return to reset values next cycle; a new message then yields a complete frame starting A5.
- Preload `frames_sent` to 16'hFFFF via 65535 frames, or force → next frame wraps it to 0.
- Assertions on every run:
  - no two consecutive `uart_tx_en` cycles
  - `uart_tx_en` is never high while `uart_tx_busy` is high
  - `msg_ready` is high exactly when `frame_active` is low

Source files
------------

// File: rtl/uart_frame_pkg.sv
// ----------------------------------------------------------------------------
// uart_frame_pkg
// Shared definitions for the UART framing stage: the framer state encoding,
// the default sync byte, the per-frame overhead and the checksum helper.
// ----------------------------------------------------------------------------
package uart_frame_pkg;

  // Framer states: IDLE waits for a message, ISSUE strobes one byte, GAP
  // covers the transmitter's delay before busy rises, DRAIN waits for busy
  // to fall.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DRAIN = 2'd3
  } frame_state_e;

  // First byte of every frame unless overridden by the instantiating parent.
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Bytes added around the payload: SYNC, LEN and CHK.
  localparam int FRAME_OVERHEAD = 3;

  // Running XOR checksum step; SYNC is never folded in.
  function automatic logic [7:0] chk_update(input logic [7:0] acc,
                                            input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/uart_frame_tx.sv
// ----------------------------------------------------------------------------
// uart_frame_tx
// Wraps one PAYLOAD_BYTES-wide message into a frame
//   SYNC_BYTE, LEN, payload[0] .. payload[N-1], CHK   (CHK = LEN ^ payload)
// and feeds it byte by byte into a UART transmitter.
//
// Ports:
//   clk           system clock
//   reset         synchronous active-high reset; abandons any frame in flight
//   msg_valid     message offered
//   msg_ready     block is idle and will accept a message
//   msg_data      message; byte 0 is [7:0] and goes out first
//   uart_tx_en    one-cycle send strobe to the transmitter (registered)
//   uart_tx_data  byte to send, valid while uart_tx_en is high (registered)
//   uart_tx_busy  transmitter is shifting a byte
//   frame_active  a frame is in progress
//   frames_sent   completed-frame counter, wraps at 16 bits
// ----------------------------------------------------------------------------
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 8,
  parameter logic [7:0] SYNC_BYTE     = DEFAULT_SYNC_BYTE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       msg_valid,
  output logic                       msg_ready,
  input  logic [PAYLOAD_BYTES*8-1:0] msg_data,
  output logic                       uart_tx_en,
  output logic [7:0]                 uart_tx_data,
  input  logic                       uart_tx_busy,
  output logic                       frame_active,
  output logic [15:0]                frames_sent
);

  localparam int               IDX_W    = $clog2(PAYLOAD_BYTES + FRAME_OVERHEAD);
  localparam logic [7:0]       LEN_BYTE = 8'(PAYLOAD_BYTES);
  localparam logic [IDX_W-1:0] IDX_SYNC = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_LEN  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_PAY0 = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_PAYN = IDX_W'(PAYLOAD_BYTES + 1);
  localparam logic [IDX_W-1:0] IDX_CHK  = IDX_W'(PAYLOAD_BYTES + 2);

  frame_state_e               state_r, nxt_state_s;
  logic [IDX_W-1:0]           idx_r, nxt_idx_s;
  logic [7:0]                 chk_r, nxt_chk_s;
  logic [PAYLOAD_BYTES*8-1:0] msg_r, nxt_msg_s;
  logic                       tx_en_r, nxt_tx_en_s;
  logic [7:0]                 tx_data_r, nxt_tx_data_s;
  logic [15:0]                frames_r, nxt_frames_s;

  logic [IDX_W-1:0]           pay_idx_s;
  logic [7:0]                 pay_byte_s;
  logic [7:0]                 cur_byte_s;
  logic                       is_payload_s;

  assign msg_ready    = (state_r == ST_IDLE);
  assign frame_active = (state_r != ST_IDLE);
  assign uart_tx_en   = tx_en_r;
  assign uart_tx_data = tx_data_r;
  assign frames_sent  = frames_r;

  // Byte mux: picks SYNC, LEN, a latched payload byte or the checksum by index.
  always_comb begin
    pay_idx_s    = idx_r - IDX_PAY0;
    pay_byte_s   = 8'(msg_r >> (8 * pay_idx_s));
    is_payload_s = (idx_r >= IDX_PAY0) && (idx_r <= IDX_PAYN);
    if (idx_r == IDX_SYNC) begin
      cur_byte_s = SYNC_BYTE;
    end else if (idx_r == IDX_LEN) begin
      cur_byte_s = LEN_BYTE;
    end else if (idx_r == IDX_CHK) begin
      cur_byte_s = chk_r;
    end else begin
      cur_byte_s = pay_byte_s;
    end
  end

  // Next-state and next-output logic for the framer.
  always_comb begin
    nxt_state_s   = state_r;
    nxt_idx_s     = idx_r;
    nxt_chk_s     = chk_r;
    nxt_msg_s     = msg_r;
    nxt_tx_en_s   = 1'b0;
    nxt_tx_data_s = tx_data_r;
    nxt_frames_s  = frames_r;
    case (state_r)
      ST_IDLE: begin
        if (msg_valid) begin
          nxt_msg_s = msg_data;
          nxt_idx_s = IDX_SYNC;
          nxt_chk_s = LEN_BYTE;
          // The accept cycle already acts as the first ISSUE evaluation, so
          // with an idle transmitter the SYNC strobe lands on the next cycle.
          if (!uart_tx_busy) begin
            nxt_tx_en_s   = 1'b1;
            nxt_tx_data_s = SYNC_BYTE;
            nxt_state_s   = ST_GAP;
          end else begin
            nxt_state_s = ST_ISSUE;
          end
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!uart_tx_busy) begin
          nxt_tx_en_s   = 1'b1;
          nxt_tx_data_s = cur_byte_s;
          if (is_payload_s) begin
            nxt_chk_s = chk_update(chk_r, cur_byte_s);
          end else begin
            nxt_chk_s = chk_r;
          end
          nxt_state_s = ST_GAP;
        end else begin
          nxt_state_s = ST_ISSUE;
        end
      end
      ST_GAP: begin
        // The strobe is visible in this cycle; busy has not risen yet.
        nxt_state_s = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!uart_tx_busy) begin
          if (idx_r == IDX_CHK) begin
            nxt_frames_s = frames_r + 16'd1;
            nxt_state_s  = ST_IDLE;
          end else begin
            nxt_idx_s   = idx_r + IDX_W'(1);
            nxt_state_s = ST_ISSUE;
          end
        end else begin
          nxt_state_s = ST_DRAIN;
        end
      end
      default: begin
        nxt_state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      idx_r     <= IDX_W'(0);
      chk_r     <= 8'h00;
      msg_r     <= '0;
      tx_en_r   <= 1'b0;
      tx_data_r <= 8'h00;
      frames_r  <= 16'd0;
    end else begin
      state_r   <= nxt_state_s;
      idx_r     <= nxt_idx_s;
      chk_r     <= nxt_chk_s;
      msg_r     <= nxt_msg_s;
      tx_en_r   <= nxt_tx_en_s;
      tx_data_r <= nxt_tx_data_s;
      frames_r  <= nxt_frames_s;
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_frame_tx
// Directed bench for uart_frame_tx with PAYLOAD_BYTES = 4. A behavioural
// transmitter model raises busy for BYTE_T cycles after each strobe, and a
// receiver log collects every strobed byte for frame comparison.
// ----------------------------------------------------------------------------
module tb_uart_frame_tx;

  localparam int N      = 4;
  localparam int BYTE_T = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          msg_valid;
  logic          msg_ready;
  logic [N*8-1:0] msg_data;
  logic          uart_tx_en;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_busy;
  logic          frame_active;
  logic [15:0]   frames_sent;

  logic          ext_hold;
  int            tx_cnt;
  logic [7:0]    rx_q[$];
  logic          prev_en;
  int            proto_err;

  int            n_pass  = 0;
  int            n_total = 0;

  uart_frame_tx #(.PAYLOAD_BYTES(N), .SYNC_BYTE(8'hA5)) dut (
    .clk          (clk),
    .reset        (reset),
    .msg_valid    (msg_valid),
    .msg_ready    (msg_ready),
    .msg_data     (msg_data),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_busy (uart_tx_busy),
    .frame_active (frame_active),
    .frames_sent  (frames_sent)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for BYTE_T cycles after each accepted strobe.
  always @(posedge clk) begin
    if (reset) tx_cnt <= 0;
    else if (uart_tx_en) tx_cnt <= BYTE_T;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end

  assign uart_tx_busy = (tx_cnt != 0) || ext_hold;

  // Receiver log of every byte strobed out of reset.
  always @(posedge clk) begin
    if (!reset && uart_tx_en) rx_q.push_back(uart_tx_data);
  end

  // Protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      assert (!(uart_tx_en && prev_en)) else begin
        $error("FAIL proto_en_twice: en high in two consecutive cycles");
        proto_err <= proto_err + 1;
      end
      assert (!(uart_tx_en && uart_tx_busy)) else begin
        $error("FAIL proto_en_busy: en high while busy high");
        proto_err <= proto_err + 1;
      end
      assert (msg_ready === !frame_active) else begin
        $error("FAIL proto_ready: msg_ready=%b frame_active=%b", msg_ready, frame_active);
        proto_err <= proto_err + 1;
      end
    end
    prev_en <= reset ? 1'b0 : uart_tx_en;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected byte i of the frame carrying message d, built independently.
  function automatic logic [7:0] exp_byte(input logic [N*8-1:0] d, input int i);
    logic [7:0] c;
    if (i == 0) return 8'hA5;
    if (i == 1) return 8'h04;
    if (i == N + 2) begin
      c = 8'h04;
      for (int k = 0; k < N; k++) c = c ^ d[8*k +: 8];
      return c;
    end
    return d[8*(i-2) +: 8];
  endfunction

  task automatic chk_frame(input string tag, input logic [N*8-1:0] d);
    chk({tag, "_len"}, 32'(rx_q.size()), 32'(N + 3));
    for (int i = 0; i < N + 3; i++) begin
      if (i < rx_q.size()) chk($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp_byte(d, i)));
    end
    rx_q.delete();
  endtask

  // Offer d and return at the negedge of the cycle after the accept edge.
  task automatic send(input logic [N*8-1:0] d);
    int n;
    @(negedge clk);
    msg_valid = 1'b1;
    msg_data  = d;
    n = 0;
    while (!msg_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(msg_ready), 32'd1);
    @(negedge clk);
    msg_valid = 1'b0;
    msg_data  = 32'hDEADBEEF;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (frame_active && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(frame_active), 32'd0);
  endtask

  initial begin
    logic [7:0] exp1 [7];
    int         en_cnt;
    int         n;
    exp1 = '{8'hA5, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40};
    reset     = 1'b1;
    msg_valid = 1'b0;
    msg_data  = '0;
    ext_hold  = 1'b0;
    proto_err = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  32'(msg_ready),    32'd1);
    chk("rst_en",     32'(uart_tx_en),   32'd0);
    chk("rst_data",   32'(uart_tx_data), 32'h00);
    chk("rst_active", 32'(frame_active), 32'd0);
    chk("rst_frames", 32'(frames_sent),  32'd0);
    reset = 1'b0;

    // Basic frame, known byte sequence, first strobe one cycle after accept.
    send(32'h44332211);
    chk("first_en",   32'(uart_tx_en),   32'd1);
    chk("first_data", 32'(uart_tx_data), 32'hA5);
    wait_idle();
    chk("t1_len", 32'(rx_q.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < rx_q.size()) chk($sformatf("t1_b%0d", i), 32'(rx_q[i]), 32'(exp1[i]));
    end
    rx_q.delete();
    chk("t1_frames", 32'(frames_sent), 32'd1);

    // Busy held externally across the accept: SYNC waits for busy to fall.
    @(negedge clk);
    ext_hold = 1'b1;
    send(32'hCAFEF00D);
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (uart_tx_en) en_cnt++;
      @(negedge clk);
    end
    chk("hold_no_en", 32'(en_cnt), 32'd0);
    ext_hold = 1'b0;
    @(negedge clk);
    chk("hold_en",   32'(uart_tx_en),   32'd1);
    chk("hold_data", 32'(uart_tx_data), 32'hA5);
    wait_idle();
    chk_frame("t2", 32'hCAFEF00D);
    chk("t2_frames", 32'(frames_sent), 32'd2);

    // Back-to-back messages: second one held off until the first completes.
    send(32'h0F1E2D3C);
    msg_valid = 1'b1;
    msg_data  = 32'h8899AABB;
    repeat (5) @(negedge clk);
    chk("b2b_held", 32'(msg_ready), 32'd0);
    n = 0;
    while (!msg_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_ready",  32'(msg_ready),   32'd1);
    chk("b2b_frames", 32'(frames_sent), 32'd3);
    @(negedge clk);
    msg_valid = 1'b0;
    msg_data  = '0;
    chk_frame("t3a", 32'h0F1E2D3C);
    wait_idle();
    chk_frame("t3b", 32'h8899AABB);
    chk("t3_frames", 32'(frames_sent), 32'd4);

    // Reset after the third strobe abandons the frame.
    send(32'h76543210);
    en_cnt = 0;
    n = 0;
    while (en_cnt < 3 && n < 400) begin
      if (uart_tx_en) en_cnt++;
      if (en_cnt < 3) @(negedge clk);
      n++;
    end
    chk("third_strobe", 32'(en_cnt), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_en",     32'(uart_tx_en),   32'd0);
    chk("mid_rst_data",   32'(uart_tx_data), 32'h00);
    chk("mid_rst_ready",  32'(msg_ready),    32'd1);
    chk("mid_rst_active", 32'(frame_active), 32'd0);
    chk("mid_rst_frames", 32'(frames_sent),  32'd0);
    reset = 1'b0;
    rx_q.delete();
    send(32'h13579BDF);
    wait_idle();
    chk_frame("t4", 32'h13579BDF);
    chk("t4_frames", 32'(frames_sent), 32'd1);

    // Counter wrap from 16'hFFFF to 0.
    @(negedge clk);
    force dut.frames_r = 16'hFFFF;
    @(negedge clk);
    release dut.frames_r;
    @(negedge clk);
    chk("preload", 32'(frames_sent), 32'hFFFF);
    send(32'h00000000);
    wait_idle();
    chk_frame("t5", 32'h00000000);
    chk("wrap", 32'(frames_sent), 32'd0);

    repeat (3) @(negedge clk);
    chk("protocol", 32'(proto_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
